universal_shift_reg: RTL and testbench

- Parameterised N-bit universal shift register with four modes: hold, shift right, shift left, parallel load.
- The mode is selected each clock by a 2-bit control.
- Serves as a generic storage/serialisation element.
- Register output q is directly visible; there is no handshake.

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_bit_cell.sv | 46 ++++
 rtl/universal_shift_reg.sv | 45 ++++
 tb/tb_universal_shift_reg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usr_pkg
// Purpose  : Shared mode encoding and default width for the universal shift
//            register.
// Revision : 1.0
// ============================================================================
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_e;

    localparam int USR_DEFAULT_WIDTH = 4;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_bit_cell.sv
`default_nettype none
// ============================================================================
// Module   : usr_bit_cell
// Purpose  : One storage bit: 4:1 mode mux (hold/right/left/load) plus flop.
// Revision : 1.0
// ============================================================================
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_ctrl,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_d,
    output logic       o_q
);

    logic r_q;
    logic w_next;

    // Shift right pulls from the left (higher) neighbour, shift left from the
    // right (lower) neighbour. Unknown modes fall back to hold.
    always_comb begin
        w_next = r_q;
        case (usr_mode_e'(i_ctrl))
            USR_HOLD: w_next = r_q;
            USR_SHR:  w_next = i_left;
            USR_SHL:  w_next = i_right;
            USR_LOAD: w_next = i_d;
            default:  w_next = r_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule : usr_bit_cell
`default_nettype wire

// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_reg
// Purpose  : WIDTH-bit universal shift register (hold, shift right, shift
//            left, parallel load) built from per-bit mux/flop cells.
// Revision : 1.0
// ============================================================================
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ctrl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;

    // Neighbour vectors: the end cells see the serial-in bits from d.
    assign w_shr = {d[WIDTH-1], w_q[WIDTH-1:1]};
    assign w_shl = {w_q[WIDTH-2:0], d[0]};

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            usr_bit_cell u_cell (
                .clk     (clk),
                .rst     (rst),
                .i_ctrl  (ctrl),
                .i_left  (w_shr[i]),
                .i_right (w_shl[i]),
                .i_d     (d[i]),
                .o_q     (w_q[i])
            );
        end
    endgenerate

    assign q = w_q;

endmodule : universal_shift_reg
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_reg
// Purpose  : Self-checking bench for universal_shift_reg (WIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_universal_shift_reg;

    localparam int WIDTH = 4;

    typedef struct {
        logic             rst;
        logic [1:0]       ctrl;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [1:0]       ctrl;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_queue[$];

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl),
        .d    (d),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: q=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, queue the expectation, and compare
    // it against q one time unit after the next rising edge.
    task automatic step(input string name, input logic r, input logic [1:0] c,
                        input logic [WIDTH-1:0] dv, input logic [WIDTH-1:0] exp);
        logic [WIDTH-1:0] e;
        @(negedge clk);
        rst  = r;
        ctrl = c;
        d    = dv;
        exp_queue.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_queue.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, q=%b", name, q);
        end else begin
            e = exp_queue.pop_front();
            check(name, q, e);
        end
    endtask

    vec_t vecs[25];

    initial begin
        rst  = 1'b1;
        ctrl = 2'b11;
        d    = 4'b1010;

        vecs[0]  = '{1'b1, 2'b11, 4'b1010, 4'b0000};
        vecs[1]  = '{1'b1, 2'b11, 4'b1010, 4'b0000};
        vecs[2]  = '{1'b0, 2'b11, 4'b1011, 4'b1011};
        vecs[3]  = '{1'b0, 2'b00, 4'b0100, 4'b1011};
        vecs[4]  = '{1'b0, 2'b00, 4'b1111, 4'b1011};
        vecs[5]  = '{1'b0, 2'b00, 4'b0000, 4'b1011};
        vecs[6]  = '{1'b0, 2'b01, 4'b0000, 4'b0101};
        vecs[7]  = '{1'b0, 2'b01, 4'b0000, 4'b0010};
        vecs[8]  = '{1'b0, 2'b11, 4'b1011, 4'b1011};
        vecs[9]  = '{1'b0, 2'b10, 4'b0001, 4'b0111};
        vecs[10] = '{1'b0, 2'b10, 4'b0001, 4'b1111};
        vecs[11] = '{1'b0, 2'b01, 4'b1000, 4'b1111};
        vecs[12] = '{1'b0, 2'b01, 4'b0111, 4'b0111};
        vecs[13] = '{1'b0, 2'b10, 4'b1110, 4'b1110};
        vecs[14] = '{1'b0, 2'b10, 4'b1110, 4'b1100};
        vecs[15] = '{1'b0, 2'b10, 4'b1110, 4'b1000};
        vecs[16] = '{1'b0, 2'b10, 4'b1110, 4'b0000};
        vecs[17] = '{1'b0, 2'b01, 4'b1000, 4'b1000};
        vecs[18] = '{1'b0, 2'b01, 4'b1000, 4'b1100};
        vecs[19] = '{1'b0, 2'b01, 4'b1000, 4'b1110};
        vecs[20] = '{1'b0, 2'b01, 4'b1000, 4'b1111};
        vecs[21] = '{1'b0, 2'b11, 4'b0001, 4'b0001};
        vecs[22] = '{1'b0, 2'b01, 4'b0000, 4'b0000};
        vecs[23] = '{1'b0, 2'b11, 4'b1000, 4'b1000};
        vecs[24] = '{1'b0, 2'b10, 4'b0000, 4'b0000};

        for (int i = 0; i < 25; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ctrl,
                 vecs[i].d, vecs[i].exp_q);
        end

        // Asynchronous assertion between edges clears q without a clock edge.
        step("async_load", 1'b0, 2'b11, 4'b1011, 4'b1011);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", q, 4'b0000);
        ctrl = 2'b11;
        d    = 4'b1111;
        @(posedge clk);
        #1;
        check("reset_priority", q, 4'b0000);
        step("post_reset_load", 1'b0, 2'b11, 4'b0110, 4'b0110);

        // Reset pulse of 3 time units in the middle of a shift run.
        step("mid_load", 1'b0, 2'b11, 4'b1111, 4'b1111);
        step("mid_shift", 1'b0, 2'b01, 4'b0000, 4'b0111);
        #1;
        rst = 1'b1;
        #1;
        check("mid_clear", q, 4'b0000);
        #2;
        rst  = 1'b0;
        ctrl = 2'b11;
        d    = 4'b0110;
        #1;
        check("mid_released", q, 4'b0000);
        @(posedge clk);
        #1;
        check("mid_resume", q, 4'b0110);

        // Changes between edges are ignored: only the value at the edge counts.
        @(negedge clk);
        ctrl = 2'b11;
        d    = 4'b1001;
        #2;
        d    = 4'b0011;
        @(posedge clk);
        #1;
        check("sample_at_edge", q, 4'b0011);

        if (exp_queue.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_queue.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule : tb_universal_shift_reg
`default_nettype wire
